lect_dato: RTL and testbench

Memory read sequencer for the 4-bit Von Neumann processor. It runs on the read side of the shared data memory; the write-side selector loads the memory data-in register. On a `start` request it issues three consecutive read strobes at `pc`, `pc+1`, `pc+2` and waits the memory read latency for each. It captures the returned nibbles as instruction, operand A and operand B, then pulses `listo` for the control unit.

---
 rtl/lect_dato.sv | 110 +++++++++++
 tb/tb_lect_dato.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lect_dato.sv
// Read sequencer for the 4-bit processor's data memory. It fetches the instruction
// and both operands from pc, pc+1 and pc+2, then pulses listo.
module lect_dato #(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pc,
    input  logic [3:0] datout,
    output logic [3:0] dir,
    output logic       rd,
    output logic [3:0] instr,
    output logic [3:0] opa,
    output logic [3:0] opb,
    output logic       ocupado,
    output logic       listo
);

    typedef enum logic [1:0] {IDLE, LEE, ESPERA, FIN} state_t;

    localparam logic [1:0] LAT_M1 = 2'(LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] base_q, base_d;
    logic [1:0] k_q, k_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] dir_q, dir_d;
    logic [3:0] instr_q, instr_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] opb_q, opb_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= '0;
            instr_q <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            instr_q <= instr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // dir is loaded on entry to LEE so it is already registered when rd is high.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        instr_d = instr_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = pc;
                    k_d     = '0;
                    dir_d   = pc;
                    state_d = LEE;
                end
            end
            LEE: begin
                cnt_d   = LAT_M1;
                state_d = ESPERA;
            end
            ESPERA: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    case (k_q)
                        2'd0:    instr_d = datout;
                        2'd1:    opa_d   = datout;
                        default: opb_d   = datout;
                    endcase
                    if (k_q != 2'd2) begin
                        k_d     = k_q + 2'd1;
                        dir_d   = base_q + {2'b00, k_q} + 4'd1;
                        state_d = LEE;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dir     = dir_q;
    assign rd      = (state_q == LEE);
    assign instr   = instr_q;
    assign opa     = opa_q;
    assign opb     = opb_q;
    assign ocupado = (state_q != IDLE);
    assign listo   = (state_q == FIN);

endmodule

// File: tb/tb_lect_dato.sv
// Scoreboard bench for lect_dato: instance 0 runs with LAT=1, instance 1 with LAT=3,
// each behind its own latency-accurate memory model.
module tb_lect_dato;

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] addr;
    } rd_t;

    typedef struct {
        int         dut;
        int         cyc;
        logic [3:0] i;
        logic [3:0] a;
        logic [3:0] b;
    } res_t;

    logic       clk;
    logic       rst;
    logic       start_w [2];
    logic [3:0] pc_w    [2];
    logic [3:0] dout_w  [2];
    logic [3:0] dir_w   [2];
    logic       rd_w    [2];
    logic [3:0] ins_w   [2];
    logic [3:0] opa_w   [2];
    logic [3:0] opb_w   [2];
    logic       ocu_w   [2];
    logic       lis_w   [2];

    logic [3:0] mem [16];
    logic [3:0] pa0 [3];
    logic [3:0] pa1 [3];
    logic [2:0] pv0 = '0;
    logic [2:0] pv1 = '0;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bfrom [2] = '{0, 0};
    int   buntil [2] = '{-1, -1};
    logic [3:0] last_dir [2] = '{4'h0, 4'h0};
    rd_t  q_rd [$];
    res_t q_res [$];

    lect_dato #(.LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_w[0]), .pc(pc_w[0]), .datout(dout_w[0]),
        .dir(dir_w[0]), .rd(rd_w[0]), .instr(ins_w[0]), .opa(opa_w[0]), .opb(opb_w[0]),
        .ocupado(ocu_w[0]), .listo(lis_w[0])
    );

    lect_dato #(.LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start_w[1]), .pc(pc_w[1]), .datout(dout_w[1]),
        .dir(dir_w[1]), .rd(rd_w[1]), .instr(ins_w[1]), .opa(opa_w[1]), .opb(opb_w[1]),
        .ocupado(ocu_w[1]), .listo(lis_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data is valid exactly LAT cycles after the rd cycle, 4'hA otherwise.
    always @(posedge clk) begin
        pv0    <= {pv0[1:0], rd_w[0]};
        pa0[0] <= dir_w[0];
        pa0[1] <= pa0[0];
        pa0[2] <= pa0[1];
        pv1    <= {pv1[1:0], rd_w[1]};
        pa1[0] <= dir_w[1];
        pa1[1] <= pa1[0];
        pa1[2] <= pa1[1];
    end

    assign dout_w[0] = pv0[0] ? mem[pa0[0]] : 4'hA;
    assign dout_w[1] = pv1[2] ? mem[pa1[2]] : 4'hA;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Issue a start at the current negedge and schedule the expected bus and result.
    task automatic go(input int d, input logic [3:0] p,
                      input logic [3:0] ei, input logic [3:0] ea, input logic [3:0] eb);
        int lat;
        int c0;
        lat = (d == 1) ? 3 : 1;
        pc_w[d]    = p;
        start_w[d] = 1'b1;
        @(posedge clk);
        #1;
        start_w[d] = 1'b0;
        c0 = cyc;
        for (int n = 0; n < 3; n++)
            q_rd.push_back('{dut: d, cyc: c0 + n * (1 + lat), addr: p + 4'(n)});
        q_res.push_back('{dut: d, cyc: c0 + 3 * (1 + lat), i: ei, a: ea, b: eb});
        bfrom[d]  = c0;
        buntil[d] = c0 + 3 * (1 + lat);
    endtask

    always @(negedge clk) begin
        rd_t  e;
        res_t r;
        for (int d = 0; d < 2; d++) begin
            chk("ocupado", 32'(ocu_w[d]), 32'(cyc >= bfrom[d] && cyc <= buntil[d]));
            if (rd_w[d]) begin
                if (q_rd.size() == 0) begin
                    chk("rd_unexpected", 32'(rd_w[d]), 32'd0);
                end else begin
                    e = q_rd.pop_front();
                    chk("rd_dut", 32'(d), 32'(e.dut));
                    chk("rd_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_dir", 32'(dir_w[d]), 32'(e.addr));
                    last_dir[d] = e.addr;
                end
            end else if (ocu_w[d]) begin
                chk("dir_held", 32'(dir_w[d]), 32'(last_dir[d]));
            end
            if (lis_w[d]) begin
                if (q_res.size() == 0) begin
                    chk("listo_unexpected", 32'(lis_w[d]), 32'd0);
                end else begin
                    r = q_res.pop_front();
                    chk("listo_dut", 32'(d), 32'(r.dut));
                    chk("listo_cycle", 32'(cyc), 32'(r.cyc));
                    chk("instr", 32'(ins_w[d]), 32'(r.i));
                    chk("opa", 32'(opa_w[d]), 32'(r.a));
                    chk("opb", 32'(opb_w[d]), 32'(r.b));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        mem[4'h4] = 4'h3; mem[4'h5] = 4'h9; mem[4'h6] = 4'hC;
        mem[4'hF] = 4'h1; mem[4'h0] = 4'h2; mem[4'h1] = 4'h7;
        mem[4'h2] = 4'h5; mem[4'h3] = 4'h6;
        mem[4'h8] = 4'hB; mem[4'h9] = 4'hD; mem[4'hA] = 4'hE;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_w[d] = 1'b0;
            pc_w[d]    = 4'h0;
        end

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_dir", 32'(dir_w[d]), 32'd0);
            chk("rst_rd", 32'(rd_w[d]), 32'd0);
            chk("rst_regs", 32'({ins_w[d], opa_w[d], opb_w[d]}), 32'd0);
            chk("rst_ocupado", 32'(ocu_w[d]), 32'd0);
            chk("rst_listo", 32'(lis_w[d]), 32'd0);
        end
        rst = 1'b0;

        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                chk("idle_regs", 32'({dir_w[d], ins_w[d], opa_w[d], opb_w[d]}), 32'd0);
        end

        // Basic fetch, LAT=1, with capture-edge checks.
        go(0, 4'h4, 4'h3, 4'h9, 4'hC);
        @(negedge clk);
        @(negedge clk);
        chk("instr_before_capture", 32'(ins_w[0]), 32'd0);
        @(negedge clk);
        chk("instr_after_capture", 32'(ins_w[0]), 32'h3);
        chk("opa_before_capture", 32'(opa_w[0]), 32'd0);
        repeat (5) @(negedge clk);

        // Earliest restart, address wrap.
        go(0, 4'hF, 4'h1, 4'h2, 4'h7);
        repeat (8) @(negedge clk);

        // start held high with a new pc through the whole fetch, then a real restart.
        go(0, 4'h4, 4'h3, 4'h9, 4'hC);
        start_w[0] = 1'b1;
        pc_w[0]    = 4'h8;
        repeat (8) @(negedge clk);
        go(0, 4'h8, 4'hB, 4'hD, 4'hE);
        repeat (8) @(negedge clk);

        // LAT=3 instance.
        go(1, 4'h2, 4'h5, 4'h6, 4'h3);
        repeat (14) @(negedge clk);

        // Mid-fetch reset after instr has been captured.
        go(0, 4'h4, 4'h3, 4'h9, 4'hC);
        repeat (4) @(negedge clk);
        chk("mid_instr", 32'(ins_w[0]), 32'h3);
        chk("mid_opa_hold", 32'(opa_w[0]), 32'hD);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_regs", 32'({dir_w[0], ins_w[0], opa_w[0], opb_w[0]}), 32'd0);
        chk("arst_ctrl", 32'({rd_w[0], ocu_w[0], lis_w[0]}), 32'd0);
        chk("arst_lat3_regs", 32'({ins_w[1], opa_w[1], opb_w[1]}), 32'd0);
        q_rd.delete();
        q_res.delete();
        buntil[0] = -1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);

        chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        chk("res_queue_drained", 32'(q_res.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
